// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: drives one external combinational 1-bit ALU
// slice LSB first, recirculates the carry through a register and assembles
// the WIDTH-bit result together with zero/overflow/cout flags.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start
// latches a, b and alu_ctl. busy stays high from the cycle after acceptance
// until done. done is a one-cycle pulse during which result and flags are
// valid; they are then held until the next accepted start. start while busy
// is dropped, never queued.
module bit_serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             s_a,
    output logic             s_b,
    output logic             s_cin,
    output logic             s_binv,
    output logic             s_less,
    output logic [1:0]       s_op,
    input  logic             s_result,
    input  logic             s_cout,
    input  logic             s_overflow,
    input  logic             s_slt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] last_idx = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q, final_word;
    logic [IW-1:0]    idx_q;
    logic [1:0]       op_q;
    logic             binv_q, slt_q, arith_q, illegal_q, carry_q;
    logic             zero_q, ovf_q, cout_q;
    logic [1:0]       dec_op;
    logic             dec_binv, dec_slt, dec_arith, dec_illegal;
    logic             run, last_bit;

    assign run      = (state_q == RUN);
    assign last_bit = run && (idx_q == last_idx);

    // Decode alu_ctl into slice controls; unknown codes run as AND and are flagged.
    always_comb begin
        dec_op      = 2'b00;
        dec_binv    = 1'b0;
        dec_slt     = 1'b0;
        dec_arith   = 1'b0;
        dec_illegal = 1'b0;
        case (alu_ctl)
            4'b0000: dec_op = 2'b00;
            4'b0001: dec_op = 2'b01;
            4'b0010: begin dec_op = 2'b10; dec_arith = 1'b1; end
            4'b0110: begin dec_op = 2'b10; dec_binv = 1'b1; dec_arith = 1'b1; end
            4'b0111: begin dec_op = 2'b11; dec_binv = 1'b1; dec_slt = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next state: accept start in IDLE, run WIDTH bit cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word seen at the RUN->DONE edge: MSB from the slice, then SLT/illegal overrides.
    always_comb begin
        final_word = result_q;
        final_word[WIDTH-1] = s_result;
        if (slt_q)     final_word = {{(WIDTH-1){1'b0}}, s_slt};
        if (illegal_q) final_word = '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latch, bit-serial accumulation, carry recirculation and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            op_q      <= 2'b00;
            binv_q    <= 1'b0;
            slt_q     <= 1'b0;
            arith_q   <= 1'b0;
            illegal_q <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= dec_op;
                        binv_q    <= dec_binv;
                        slt_q     <= dec_slt;
                        arith_q   <= dec_arith;
                        illegal_q <= dec_illegal;
                        result_q  <= '0;
                        idx_q     <= '0;
                        zero_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        cout_q    <= 1'b0;
                        // binv doubles as the +1 of two's-complement subtraction.
                        carry_q   <= dec_binv;
                    end
                end
                RUN: begin
                    carry_q <= s_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (last_bit) begin
                        result_q <= final_word;
                        zero_q   <= (final_word == '0);
                        cout_q   <= arith_q ? s_cout : 1'b0;
                        ovf_q    <= arith_q ? s_overflow : 1'b0;
                    end else begin
                        result_q[idx_q] <= s_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_a       = run ? a_q[idx_q] : 1'b0;
    assign s_b       = run ? b_q[idx_q] : 1'b0;
    assign s_cin     = run ? carry_q : 1'b0;
    assign s_binv    = run ? binv_q : 1'b0;
    assign s_op      = run ? op_q : 2'b00;
    assign s_less    = 1'b0;

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign cout      = cout_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq with a behavioural 1-bit ALU slice
// closing the loop around the sequencer.
module tb_bit_serial_alu_seq;

    localparam int WIDTH = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic [3:0]       alu_ctl = 4'b0000;
    logic             s_a, s_b, s_cin, s_binv, s_less;
    logic [1:0]       s_op;
    logic             s_result, s_cout, s_overflow, s_slt;
    logic             busy, done, zero, overflow, cout, illegal;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
        .s_a(s_a), .s_b(s_b), .s_cin(s_cin), .s_binv(s_binv), .s_less(s_less), .s_op(s_op),
        .s_result(s_result), .s_cout(s_cout), .s_overflow(s_overflow), .s_slt(s_slt),
        .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
        .cout(cout), .illegal(illegal), .dbg_state(dbg_state)
    );

    // Behavioural 1-bit ALU slice: b optionally inverted, full adder,
    // overflow = cin ^ cout, slt = overflow ^ sum, result muxed by op.
    logic bb, sum;
    always_comb begin
        bb         = s_b ^ s_binv;
        sum        = s_a ^ bb ^ s_cin;
        s_cout     = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
        s_overflow = s_cin ^ s_cout;
        s_slt      = s_overflow ^ sum;
        case (s_op)
            2'b00:   s_result = s_a & bb;
            2'b01:   s_result = s_a | bb;
            2'b10:   s_result = sum;
            default: s_result = s_less;
        endcase
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; returns after the accepting edge (+1 time unit).
    task automatic launch(input logic [3:0] ctl, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(posedge clk); #1;
        alu_ctl = ctl; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done; cyc counts edges since the start drive edge (accept edge = 1).
    task automatic wait_done(output int cyc);
        cyc = 1;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL done_timeout observed %0d expected %0d", done, 1);
        end
    endtask

    // Full operation with result/flag checks and pulse/hold checks afterwards.
    task automatic run_op(input string tag, input logic [3:0] ctl,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                          input logic exp_cout, input logic exp_ovf, input logic exp_ill);
        int cyc;
        launch(ctl, av, bv);
        wait_done(cyc);
        check({tag, "_latency"}, WIDTH'(cyc), WIDTH'(WIDTH + 1));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, WIDTH'(zero), WIDTH'(exp_zero));
        check({tag, "_cout"}, WIDTH'(cout), WIDTH'(exp_cout));
        check({tag, "_ovf"}, WIDTH'(overflow), WIDTH'(exp_ovf));
        check({tag, "_illegal"}, WIDTH'(illegal), WIDTH'(exp_ill));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, WIDTH'({done, busy}), WIDTH'(0));
        check({tag, "_hold"}, result, exp_res);
    endtask

    initial begin : stimulus
        int cyc;
        int done_cnt;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", WIDTH'(dbg_state), WIDTH'(0));
        check("rst_flags", WIDTH'({busy, done, zero, overflow, cout, illegal}), WIDTH'(0));
        check("rst_result", result, '0);
        check("rst_slice", WIDTH'({s_a, s_b, s_cin, s_binv, s_less, s_op}), WIDTH'(0));
        rst = 1'b0;

        // slice drive during the first RUN cycle of a SUB
        launch(4'b0110, 32'h0000_0003, 32'h0000_0005);
        check("run_state", WIDTH'(dbg_state), WIDTH'(1));
        check("run_busy", WIDTH'({busy, done}), WIDTH'(2'b10));
        check("run_slice", WIDTH'({s_a, s_b, s_cin, s_binv, s_less, s_op}), WIDTH'(7'b1111010));
        wait_done(cyc);
        check("sub_neg_result", result, 32'hFFFF_FFFE);
        check("sub_neg_flags", WIDTH'({zero, cout, overflow}), WIDTH'(0));
        @(posedge clk); #1;

        run_op("add", 4'b0010, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq", 4'b0110, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFB, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("illegal", 4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // start pulsed mid-RUN is ignored: one done, original operation result
        launch(4'b0010, 32'd100, 32'd23);
        repeat (4) @(posedge clk);
        #1;
        alu_ctl = 4'b0000; a = '0; b = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            if (done) check("ign_result", result, 32'd123);
            @(posedge clk); #1;
        end
        check("ign_done_count", WIDTH'(done_cnt), WIDTH'(1));

        // reset at cycle 10 of RUN: back to IDLE, cleared, no done
        launch(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_state", WIDTH'(dbg_state), WIDTH'(0));
        check("mid_rst_flags", WIDTH'({busy, done, zero, overflow, cout, illegal}), WIDTH'(0));
        check("mid_rst_result", result, '0);
        check("mid_rst_slice", WIDTH'({s_a, s_b, s_cin, s_binv, s_less, s_op}), WIDTH'(0));
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_done", WIDTH'(done_cnt), WIDTH'(0));

        // rst and start together: rst wins
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; alu_ctl = 4'b0010;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", WIDTH'(dbg_state), WIDTH'(0));

        run_op("after_rst", 4'b0010, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Sequencer that wraps one combinational 1-bit ALU slice (inputs a, b, cin, binv, less, Operation; outputs result, cout, overflow, slt).
- Performs a full WIDTH-bit AND/OR/ADD/SUB/SLT one bit per clock, LSB first.
- Drives the slice inputs, consumes its outputs, recirculates the carry and assembles the word result.
- Sits between the datapath operand registers and the writeback register, in place of a WIDTH-slice ripple ALU.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- alu_ctl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; latched on accepted start.
- s_a  output  1  to slice a.
- s_b  output  1  to slice b.
- s_cin  output  1  to slice cin.
- s_binv  output  1  to slice binv.
- s_less  output  1  to slice less.
- s_op  output  2  to slice Operation.
- s_result  input  1  from slice result.
- s_cout  input  1  from slice cout.
- s_overflow  input  1  from slice overflow.
- s_slt  input  1  from slice slt.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  final word; held until next accepted start.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- cout  output  1  carry out of MSB (ADD/SUB only).
- illegal  output  1  alu_ctl code not in the supported list.

Behaviour:
- Reset: state=IDLE. busy, done, result, zero, overflow, cout, illegal are all 0. Bit index 0, carry register 0. All s_* outputs 0.
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH cycles.
  - DONE -> IDLE after 1 cycle.
  - start in RUN or DONE is ignored. No queueing.
- Accepted start:
  - Latch a, b and decoded controls (op, binv).
  - Clear result, bit index and flags.
  - Load the carry register with binv.
- Decode table:
  - AND: op=00, binv=0.
  - OR: op=01, binv=0.
  - ADD: op=10, binv=0.
  - SUB: op=10, binv=1.
  - SLT: op=11, binv=1.
  - Any other code: illegal=1, op=00, binv=0. The sequence runs normally; result forced to 0 at DONE.
- RUN, bit index i:
  - s_a = A[i], s_b = B[i], s_cin = carry register, s_binv = latched binv, s_op = latched op. s_less is always 0.
  - s_* are combinational from registers. The slice is combinational and is sampled in the same cycle.
  - Each edge: result[i] <= s_result, carry <= s_cout, i <= i+1.
- MSB cycle (i = WIDTH-1):
  - Capture s_cout into cout, s_overflow into overflow, s_slt into the set bit.
- RUN->DONE edge:
  - If SLT: result <= {WIDTH-1 zeros, set}.
  - If op is not ADD/SUB: overflow and cout forced to 0.
  - zero computed from the final result.
- DONE: done=1 for exactly one cycle. result and flags stay stable until the next accepted start.
- Latency: start high at edge 0 gives done high after edge WIDTH+1. Next start is accepted at the earliest in the cycle after done.
- s_* outputs are 0 outside RUN.
- Reset mid-operation: returns to IDLE on the next edge, all outputs cleared as in reset, operation discarded, no done pulse.
- Simultaneous rst and start: rst wins.
- Arithmetic is modulo 2^WIDTH.
- SLT uses the slice's slt = overflow ^ sum, so it is correct across signed overflow.

Test Plan:
- ADD, a=5, b=3, WIDTH=32 -> result=8, zero=0, cout=0, overflow=0; done pulses exactly once, 33 cycles after start.
- SUB, a=3, b=5 -> result=0xFFFFFFFE, cout=0, overflow=0; a=b=0x1234 -> result=0, zero=1, cout=1.
- ADD, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, cout=0; SUB, a=0x80000000, b=1 -> overflow=1.
- SLT, a=0xFFFFFFFB (-5), b=3 -> result=1. SLT, a=0x7FFFFFFF, b=0x80000000 -> result=0, overflow output 0.
- AND/OR/illegal, a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - alu_ctl=1111 -> illegal=1, result=0, zero=1.
- Control:
  - start pulsed during RUN -> ignored, single done.
  - rst asserted at cycle 10 of RUN -> IDLE next edge, outputs 0, no done.
  - A new start after that -> correct result.
